raw_pixel_packer: RTL

RAW_PIXEL_PACKER -- requirements
Module: raw_pixel_packer

---
 rtl/raw_pixel_packer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/raw_pixel_packer.sv
// raw_pixel_packer: packs 8-bit raw Bayer pixels from a DVP capture stage into
// 32-bit words (first pixel in [7:0]). Each word is tagged start-of-frame and
// end-of-line and queued in a first-word-fall-through output FIFO.
//
// Ports
//   PCLK                 pixel clock, rising edge
//   Rst                  synchronous active-high reset
//   in_valid, in_pixel   raw pixel qualifier and data
//   in_hs, in_vs         line-active and frame-active levels
//   out_valid/out_ready  FIFO head handshake
//   out_data             four packed pixels of the head entry
//   out_sof, out_eol     head entry is the first word of a frame / last word of a line
//   overflow             sticky: a word was dropped because the FIFO was full
//   frame_cnt            frames started since reset (wraps)
module raw_pixel_packer #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        PCLK,
    input  logic        Rst,
    input  logic        in_valid,
    input  logic [7:0]  in_pixel,
    input  logic        in_hs,
    input  logic        in_vs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [31:0] data;
    } fifoWord_t;

    // Edge-detect registers and packing state
    logic        vsQ;
    logic        hsQ;
    logic        vsArmed;
    logic [1:0]  byteIdx;
    logic [31:0] partWord;
    logic [31:0] pendWord;
    logic        pendValid;
    logic        sofFlag;

    logic        frameStart;
    logic        vsFall;
    logic        lineEnd;
    logic        accept;

    logic [1:0]  nextIdx;
    logic [31:0] nextPart;
    logic [31:0] nextPend;
    logic        nextPendValid;
    logic        pushReq;
    logic [31:0] pushData;
    logic        pushEol;

    // FIFO state
    fifoWord_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [CNT_W-1:0]      count;
    logic                  pop;
    logic                  wrEn;
    fifoWord_t             headWord;

    // A frame start only counts once in_vs has been seen low since reset,
    // so a frame already in progress at reset release is not counted.
    assign frameStart = in_vs & ~vsQ & vsArmed;
    assign vsFall     = ~in_vs & vsQ;
    assign lineEnd    = ~in_hs & hsQ;
    assign accept     = in_valid & in_vs & ~lineEnd;

    // Pixel packing: frame abort beats line end, line end beats a new pixel.
    always_comb begin
        nextIdx       = byteIdx;
        nextPart      = partWord;
        nextPend      = pendWord;
        nextPendValid = pendValid;
        pushReq       = 1'b0;
        pushData      = 32'h0;
        pushEol       = 1'b0;
        if (vsFall) begin
            nextIdx       = 2'd0;
            nextPart      = 32'h0;
            nextPendValid = 1'b0;
        end else if (lineEnd) begin
            if (pendValid) begin
                pushReq  = 1'b1;
                pushData = pendWord;
                pushEol  = 1'b1;
            end else if (byteIdx != 2'd0) begin
                pushReq  = 1'b1;
                pushData = partWord;
                pushEol  = 1'b1;
            end
            nextIdx       = 2'd0;
            nextPart      = 32'h0;
            nextPendValid = 1'b0;
        end else if (accept) begin
            if (pendValid) begin
                pushReq       = 1'b1;
                pushData      = pendWord;
                nextPendValid = 1'b0;
            end
            if (byteIdx == 2'd3) begin
                nextPend      = partWord | (32'(in_pixel) << 24);
                nextPendValid = 1'b1;
                nextPart      = 32'h0;
            end else begin
                nextPart = partWord | (32'(in_pixel) << {byteIdx, 3'b000});
            end
            nextIdx = byteIdx + 2'd1;
        end
    end

    // Packing state, sof flag and frame counter
    always_ff @(posedge PCLK) begin
        if (Rst) begin
            vsQ       <= 1'b0;
            hsQ       <= 1'b0;
            vsArmed   <= 1'b0;
            byteIdx   <= 2'd0;
            partWord  <= 32'h0;
            pendWord  <= 32'h0;
            pendValid <= 1'b0;
            sofFlag   <= 1'b0;
            frame_cnt <= 16'h0;
        end else begin
            vsQ       <= in_vs;
            hsQ       <= in_hs;
            if (!in_vs) begin
                vsArmed <= 1'b1;
            end
            byteIdx   <= nextIdx;
            partWord  <= nextPart;
            pendWord  <= nextPend;
            pendValid <= nextPendValid;
            if (frameStart) begin
                sofFlag   <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (pushReq) begin
                sofFlag <= 1'b0;
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pop  = out_valid & out_ready;
    assign wrEn = pushReq & ((count < CNT_W'(FIFO_DEPTH)) | pop);

    always_ff @(posedge PCLK) begin
        if (Rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(wrEn) - CNT_W'(pop);
            if (pushReq && !wrEn) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge PCLK) begin
        if (wrEn) begin
            mem[wrPtr] <= '{sof: sofFlag, eol: pushEol, data: pushData};
        end
    end

    assign headWord  = mem[rdPtr];
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? headWord.data : 32'h0;
    assign out_sof   = out_valid & headWord.sof;
    assign out_eol   = out_valid & headWord.eol;

endmodule
